// File: rtl/traffic_pkg.sv
// Shared light encodings and checker phase codes for the highway/local-road
// traffic light system.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRE = 3'b100;

    // Checker states double as the controller's phase codes.
    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        RR1 = 3'd2,
        LG  = 3'd3,
        LY  = 3'd4,
        RR2 = 3'd5,
        ERR = 3'd6
    } phase_e;

    // Expected {hw_light, lr_light} pair for each phase.
    function automatic logic [5:0] phase_pair(input phase_e p);
        logic [5:0] pair;
        case (p)
            HG:       pair = {GRE, RED};
            HY:       pair = {YEL, RED};
            RR1, RR2: pair = {RED, RED};
            LG:       pair = {RED, GRE};
            LY:       pair = {RED, YEL};
            default:  pair = 6'b000000;
        endcase
        return pair;
    endfunction

    // Successor in the legal phase cycle.
    function automatic phase_e phase_next(input phase_e p);
        phase_e n;
        case (p)
            HG:      n = HY;
            HY:      n = RR1;
            RR1:     n = LG;
            LG:      n = LY;
            LY:      n = RR2;
            RR2:     n = HG;
            default: n = ERR;
        endcase
        return n;
    endfunction

    function automatic logic is_light(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRE);
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Tracks the controller's light phase and flags any illegal light pair or
// illegal phase transition. The error is sticky until reset.
module light_seq_checker
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    input  logic       lr_has_car,
    output logic       light_err
);

    phase_e     state_q, state_d;
    logic       has_car_q;  // lr_has_car as seen in the previous cycle
    logic [5:0] pair;

    assign pair = {hw_light, lr_light};

    // Next phase: stay on a matching pair, advance on the successor pair, else error.
    always_comb begin
        state_d = state_q;
        if (state_q == ERR) begin
            state_d = ERR;
        end else if (!is_light(hw_light) || !is_light(lr_light)) begin
            state_d = ERR;
        end else if (pair == phase_pair(state_q)) begin
            state_d = state_q;
        end else if (pair == phase_pair(phase_next(state_q))) begin
            // Highway may only yield when a local car was already waiting.
            if (state_q == HG && !has_car_q) begin
                state_d = ERR;
            end else begin
                state_d = phase_next(state_q);
            end
        end else begin
            state_d = ERR;
        end
    end

    // Phase register and delayed car-request copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HG;
            has_car_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            has_car_q <= lr_has_car;
        end
    end

    assign light_err = (state_q == ERR);

endmodule

// File: rtl/lr_traffic_queue.sv
// Local-road car queue: counts waiting cars, requests green from the
// controller, releases one car per green cycle and checks the light sequence.
module lr_traffic_queue
    import traffic_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_arrive,
    input  logic [2:0]       hw_light,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] car_count,
    output logic             car_depart,
    output logic             overflow,
    output logic             light_err
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             depart_q;
    logic             overflow_q, overflow_d;
    logic             go;
    logic             full;

    assign go   = (lr_light == GRE) && (count_q != '0);
    assign full = (count_q == CNT_W'(DEPTH));

    // Next count: arrivals add, green departures subtract, both cancel.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (car_arrive && !go) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (go && !car_arrive) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            depart_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            depart_q   <= go;
            overflow_q <= overflow_d;
        end
    end

    assign car_count  = count_q;
    assign lr_has_car = (count_q != '0);
    assign car_depart = depart_q;
    assign overflow   = overflow_q;

    light_seq_checker u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .light_err  (light_err)
    );

endmodule

// File: tb/tb_lr_traffic_queue.sv
// Directed bench for lr_traffic_queue with a scoreboard of expected outputs.
module tb_lr_traffic_queue;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_arrive = 1'b0;
    logic [2:0] hw_light = GRE;
    logic [2:0] lr_light = RED;
    logic       lr_has_car;
    logic [3:0] car_count;
    logic       car_depart;
    logic       overflow;
    logic       light_err;

    lr_traffic_queue #(
        .DEPTH (15),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .car_arrive (car_arrive),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .car_count  (car_count),
        .car_depart (car_depart),
        .overflow   (overflow),
        .light_err  (light_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cnt;
        logic       has;
        logic       dep;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (post-edge values).
    int   m_cnt = 0;
    logic m_ovf = 1'b0;
    logic m_err = 1'b0;
    logic m_dep = 1'b0;

    task automatic check_out(input string tag);
        exp_t e;
        exp_t o;
        o = {car_count, lr_has_car, car_depart, overflow, light_err};
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, o);
            $error("%s: no expected entry", tag);
            return;
        end
        e = sb.pop_front();
        assert (o === e) else begin
            n_bad++;
            $display("FAIL %s: observed cnt=%0d has=%b dep=%b ovf=%b err=%b | expected cnt=%0d has=%b dep=%b ovf=%b err=%b",
                     tag, o.cnt, o.has, o.dep, o.ovf, o.err, e.cnt, e.has, e.dep, e.ovf, e.err);
            $error("%s: output differs", tag);
        end
    endtask

    // Drive one cycle of inputs, predict the outcome, clock, compare.
    task automatic step(input logic arr, input logic [2:0] hw, input logic [2:0] lr,
                        input logic viol, input string tag);
        logic go;
        car_arrive = arr;
        hw_light   = hw;
        lr_light   = lr;
        go = (lr == GRE) && (m_cnt != 0);
        if (arr && !go) begin
            if (m_cnt == 15) m_ovf = 1'b1;
            else             m_cnt = m_cnt + 1;
        end else if (go && !arr) begin
            m_cnt = m_cnt - 1;
        end
        m_dep = go;
        m_err = m_err | viol;
        sb.push_back({4'(m_cnt), (m_cnt != 0), m_dep, m_ovf, m_err});
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic steps(input int n, input logic arr, input logic [2:0] hw,
                         input logic [2:0] lr, input string tag);
        for (int i = 0; i < n; i++) step(arr, hw, lr, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        car_arrive = 1'b0;
        hw_light   = GRE;
        lr_light   = RED;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        m_dep = 1'b0;
        sb.push_back({4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check_out(tag);
        n_cmp++;
        assert (dut.u_checker.state_q === HG) else begin
            n_bad++;
            $display("FAIL %s_fsm: observed state=%0d expected state=%0d",
                     tag, dut.u_checker.state_q, HG);
            $error("%s: checker not in HG", tag);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset, then an idle highway-green period.
        do_reset("reset0");
        steps(20, 1'b0, GRE, RED, "idle_hg");

        // Three arrivals under highway green.
        steps(3, 1'b1, GRE, RED, "arrive3");

        // Legal hand-over to the local road; two cars leave on green.
        steps(3, 1'b0, YEL, RED, "hy");
        steps(1, 1'b0, RED, RED, "rr1");
        steps(2, 1'b0, RED, GRE, "lg_drain");

        // Arrivals held high: count holds during green, grows after it.
        steps(3, 1'b1, RED, GRE, "lg_hold");
        steps(2, 1'b1, RED, YEL, "ly_grow");
        steps(1, 1'b0, RED, RED, "rr2");
        steps(1, 1'b0, GRE, RED, "hg_back");

        // Fill to DEPTH and push one past it.
        steps(13, 1'b1, GRE, RED, "fill");

        // Drain completely; overflow must stay set.
        steps(1, 1'b0, YEL, RED, "hy2");
        steps(1, 1'b0, RED, RED, "rr1b");
        steps(16, 1'b0, RED, GRE, "drain_all");
        steps(1, 1'b0, RED, YEL, "ly2");
        steps(1, 1'b0, RED, RED, "rr2b");
        steps(2, 1'b0, GRE, RED, "hg_empty");

        // Highway yields with no waiting car: error, then sticky.
        step(1'b0, YEL, RED, 1'b1, "hy_no_car");
        steps(3, 1'b0, GRE, RED, "err_sticky");

        do_reset("reset1");

        // Non-one-hot local light.
        step(1'b0, GRE, 3'b011, 1'b1, "bad_code");
        steps(2, 1'b1, GRE, RED, "err_sticky2");

        do_reset("reset2");
        steps(2, 1'b0, GRE, RED, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
